// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer: byte-serial wide add/subtract over one shared 8-bit adder
module multibyte_add_sequencer #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] op_a,
    input  logic [8*NUM_BYTES-1:0] op_b,
    input  logic                   op_cin,
    input  logic                   op_sub,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   cout,
    output logic                   ovf
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_r, b_r, res_r;
    logic          carry, a_msb, b_msb, rdy, last;

    // Operands shift right one byte per RUN cycle, so the adder always sees the low byte;
    // sum bytes shift in from the top and land in place after NUM_BYTES steps.
    assign last      = cnt == CW'(NUM_BYTES - 1);
    assign in_ready  = rdy;
    assign out_valid = state == DONE;
    assign add_a     = state == RUN ? a_r[7:0] : 8'h00;
    assign add_b     = state == RUN ? b_r[7:0] : 8'h00;
    assign add_cin   = state == RUN && carry;
    assign result    = out_valid ? res_r : '0;
    assign cout      = out_valid && carry;
    assign ovf       = out_valid && (a_msb == b_msb) && (res_r[W-1] != a_msb);

    // Next-state decode; only the registered ready gates acceptance
    always_comb begin
        state_n = state == IDLE ? ((rdy && in_valid) ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) :
                  state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
    end

    // Operand capture, byte stepping and result assembly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            state <= state_n;
            rdy   <= state_n == IDLE;
            if (state == IDLE && rdy && in_valid) begin
                a_r   <= op_a;
                b_r   <= op_sub ? ~op_b : op_b;
                carry <= op_sub | op_cin;
                a_msb <= op_a[W-1];
                b_msb <= op_sub ? ~op_b[W-1] : op_b[W-1];
                cnt   <= '0;
            end else if (state == RUN) begin
                res_r <= {add_sum, res_r[W-1:8]};
                carry <= add_cout;
                a_r   <= a_r >> 8;
                b_r   <= b_r >> 8;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb_multibyte_add_sequencer: random and directed checks against an arithmetic reference
module tb_multibyte_add_sequencer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, op_cin, op_sub;
    logic [31:0] op_a, op_b, result;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout, out_valid, out_ready, cout, ovf;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // Shared external adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    multibyte_add_sequencer #(.NUM_BYTES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {63'h0, in_ready}, 64'h1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input int hold);
        logic [63:0] a64, be, s, lo;
        logic [63:0] c0;
        longint sa, sb, sr;
        logic eovf;
        a64  = {32'h0, a};
        be   = {32'h0, sub ? ~b : b};
        c0   = sub ? 64'h1 : {63'h0, cin};
        s    = a64 + be + c0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sr   = sub ? sa - sb : sa + sb + longint'(cin);
        eovf = sr > 64'sd2147483647 || sr < -64'sd2147483648;
        wait_ready();
        in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            lo = (64'h1 << (8 * k)) - 64'h1;
            check("bus_a", {56'h0, add_a}, (a64 >> (8 * k)) & 64'hFF);
            check("bus_b", {56'h0, add_b}, (be >> (8 * k)) & 64'hFF);
            check("bus_cin", {63'h0, add_cin}, (((a64 & lo) + (be & lo) + c0) >> (8 * k)) & 64'h1);
            check("run_out_valid", {63'h0, out_valid}, 64'h0);
            check("run_in_ready", {63'h0, in_ready}, 64'h0);
            in_valid = 1'($urandom_range(1));
            op_a = $urandom; op_b = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency_out_valid", {63'h0, out_valid}, 64'h1);
        check("result", {32'h0, result}, s & 64'hFFFF_FFFF);
        check("cout", {63'h0, cout}, (s >> 32) & 64'h1);
        check("ovf", {63'h0, ovf}, {63'h0, eovf});
        check("done_in_ready", {63'h0, in_ready}, 64'h0);
        check("done_bus_idle", {47'h0, add_a, add_b, add_cin}, 64'h0);
        repeat (hold) begin
            in_valid = 1'b1; op_a = $urandom;
            @(negedge clk);
            check("hold_out_valid", {63'h0, out_valid}, 64'h1);
            check("hold_result", {31'h0, cout, result}, {31'h0, s[32:0]});
            check("hold_ovf", {63'h0, ovf}, {63'h0, eovf});
            check("hold_in_ready", {63'h0, in_ready}, 64'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", {63'h0, out_valid}, 64'h0);
        check("post_in_ready", {63'h0, in_ready}, 64'h1);
        check("post_result", {31'h0, cout, result}, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {63'h0, in_ready}, 64'h0);
        check("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check("reset_outputs", {29'h0, result, cout, ovf, add_cin}, 64'h0);
        check("reset_bus", {48'h0, add_a, add_b}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", {63'h0, in_ready}, 64'h1);

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 0);
        do_op(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 3);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2);

        // abort while byte 2 is on the adder bus
        wait_ready();
        in_valid = 1'b1; op_a = 32'h1122_3344; op_b = 32'h5566_7788; op_cin = 1'b0; op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_bus_byte2", {56'h0, add_a}, 64'h22);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", {63'h0, out_valid}, 64'h0);
        check("abort_outputs", {31'h0, result, cout}, 64'h0);
        check("abort_bus", {47'h0, add_a, add_b, add_cin}, 64'h0);
        check("abort_in_ready", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        check("abort_release_ready", {63'h0, in_ready}, 64'h1);
        do_op(32'h1, 32'h1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom_range(3) == 0 ? 32'hFFFF_FFFF : $urandom;
            rb = $urandom_range(3) == 0 ? 32'h8000_0000 : $urandom;
            do_op(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
Byte-serial multi-precision add/subtract controller that time-shares one external 8-bit combinational adder (a, b, cin -> sum, cout).
- Accepts two NUM_BYTES-wide operands over a valid/ready handshake.
- Drives one byte pair per cycle into the adder, LSB first, chaining the carry.
- Assembles the wide result and returns it with carry and signed overflow over a second valid/ready handshake.
- Sits between the command source and the shared adder instance.

Parameters:
NUM_BYTES, 4, operand width in bytes (legal range 2..16; W = 8*NUM_BYTES)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operand request valid
in_ready  output  1  sequencer can accept a request
op_a  input  W  operand A
op_b  input  W  operand B
op_cin  input  1  carry-in (ignored when op_sub=1)
op_sub  input  1  1 = compute A-B, 0 = compute A+B+op_cin
add_a  output  8  byte to shared adder input a
add_b  output  8  byte to shared adder input b
add_cin  output  1  carry to shared adder input cin
add_sum  input  8  shared adder sum
add_cout  input  1  shared adder carry-out
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  wide sum/difference
cout  output  1  final carry-out; in subtract mode 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, byte counter=0, operand/result registers=0.
  - in_ready=0 during the reset cycle, then 1 from the first edge with rst_n=1.
  - out_valid=0, result=0, cout=0, ovf=0, add_a/add_b/add_cin=0.
  - Reset mid-operation aborts the operation silently. No partial result is ever presented.
- States:
  - IDLE: in_ready=1. in_valid=1 at edge T latches op_a, op_b (inverted if op_sub), carry (op_sub ? 1 : op_cin) -> RUN, counter=0.
  - RUN: in_ready=0.
    - add_a/add_b = byte[counter] of latched operands; add_cin = chained carry.
    - At each edge: add_sum is stored into result byte[counter] and add_cout into the carry register; counter increments.
    - Byte k is presented during cycle T+1+k. After byte NUM_BYTES-1 -> DONE.
  - DONE: out_valid=1; result, cout, ovf stable. out_ready=1 at an edge -> IDLE.
- Latency: out_valid first asserts in cycle T+1+NUM_BYTES (5 cycles after accept for NUM_BYTES=4).
- Back-to-back operation:
  - in_ready is registered and is never 1 in the same cycle as out_valid.
  - The next accept is possible at the earliest one cycle after the result handshake.
  - Throughput is one operation per NUM_BYTES+2 cycles.
- Combinational path: none from in_valid or out_ready to in_ready or out_valid.
- Adder outputs: add_a/add_b/add_cin are driven to 0 outside RUN.
- Carry and overflow:
  - cout = add_cout of the last byte.
  - ovf = (a_msb == b_eff_msb) && (result_msb != a_msb), where b_eff is the possibly inverted B.
- Wrap-around: results are modulo 2^W, with no saturation.
- Ignored inputs: in_valid in RUN/DONE is ignored (not queued). out_ready outside DONE is ignored.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold indefinitely.

Test Plan:
- Carry ripple: NUM_BYTES=4, A=0xFFFFFFFF, B=0x00000001, cin=0, add -> result=0x00000000, cout=1, ovf=0; out_valid asserts exactly 5 cycles after accept.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add -> result=0x80000000, cout=0, ovf=1.
- Subtract with borrow: A=5, B=7, op_sub=1 -> result=0xFFFFFFFE, cout=0, ovf=0. Also A=7, B=5 -> result=2, cout=1.
- Inter-byte carry chaining and bus observation: A=0x00FF00FF, B=0x00010001, cin=1 -> result=0x01000101, cout=0. add_a/add_b/add_cin per cycle = (FF,01,1), (00,00,1), (FF,01,0), (00,00,1).
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result/cout/ovf stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 for one edge while byte 2 is on the adder bus -> next cycle out_valid=0, result=0, add_* = 0. After release in_ready=1, and a fresh request 1+1 yields result=2 with correct latency.
